// File: rtl/arilla_bus_arbiter.sv
`default_nettype none
// ============================================================================
// arilla_bus_arbiter -- two-master / one-slave memory-port arbiter with a
// registered hold buffer. Optional watchdog: ARILLA_ARB_TIMEOUT_EN. Rev 1.0
// ============================================================================
module arilla_bus_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int BYTE_SIZE      = 8,
  parameter bit ROUND_ROBIN    = 1'b0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_m0_req,
  input  logic                             i_m0_we,
  input  logic [ADDR_WIDTH-1:0]            i_m0_addr,
  input  logic [DATA_WIDTH-1:0]            i_m0_wdata,
  input  logic [DATA_WIDTH/BYTE_SIZE-1:0]  i_m0_be,
  output logic [DATA_WIDTH-1:0]            o_m0_rdata,
  output logic                             o_m0_ack,
  output logic                             o_m0_err,
  input  logic                             i_m1_req,
  input  logic                             i_m1_we,
  input  logic [ADDR_WIDTH-1:0]            i_m1_addr,
  input  logic [DATA_WIDTH-1:0]            i_m1_wdata,
  input  logic [DATA_WIDTH/BYTE_SIZE-1:0]  i_m1_be,
  output logic [DATA_WIDTH-1:0]            o_m1_rdata,
  output logic                             o_m1_ack,
  output logic                             o_m1_err,
  output logic                             o_s_req,
  output logic                             o_s_we,
  output logic [ADDR_WIDTH-1:0]            o_s_addr,
  output logic [DATA_WIDTH-1:0]            o_s_wdata,
  output logic [DATA_WIDTH/BYTE_SIZE-1:0]  o_s_be,
  input  logic [DATA_WIDTH-1:0]            i_s_rdata,
  input  logic                             i_s_ack,
  output logic                             o_busy,
  output logic                             o_owner
);

  localparam int c_BE_W = DATA_WIDTH / BYTE_SIZE;

  if ((c_BE_W * BYTE_SIZE != DATA_WIDTH) || (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
    $error("arilla_bus_arbiter: inconsistent parameters");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_owner;
  logic                    r_rr_next;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [c_BE_W-1:0]       r_be;

  logic                    w_any;
  logic                    w_grant;
  logic                    w_winner;
  logic                    w_sack;
  logic                    w_timeout;
  logic                    w_done;
  logic                    w_m0_ack;
  logic                    w_m1_ack;
  logic                    w_m0_err;
  logic                    w_m1_err;
  logic [DATA_WIDTH-1:0]   w_m0_rdata;
  logic [DATA_WIDTH-1:0]   w_m1_rdata;

  assign w_any   = i_m0_req | i_m1_req;
  assign w_grant = (r_state == ST_IDLE) & w_any;
  assign w_sack  = (r_state == ST_BUSY) & i_s_ack;
  assign w_done  = w_sack | w_timeout;

  // r_rr_next names the master preferred on the next tie.
  always_comb begin
    if (i_m0_req & i_m1_req) begin
      w_winner = ROUND_ROBIN ? r_rr_next : 1'b1;
    end else begin
      w_winner = i_m1_req;
    end
  end

`ifdef ARILLA_ARB_TIMEOUT_EN
  localparam int c_CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_CNT_W   = (c_CNT_RAW < 8) ? 8 : ((c_CNT_RAW > 32) ? 32 : c_CNT_RAW);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = 1;

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_grant) begin
      r_cnt <= '0;
    end else if (r_state == ST_BUSY) begin
      r_cnt <= r_cnt + c_CNT_ONE;
    end
  end

  // A coincident s_ack takes precedence over the watchdog.
  assign w_timeout = (r_state == ST_BUSY) & ~i_s_ack & (r_cnt == c_CNT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_m0_ack    = 1'b0;
    w_m1_ack    = 1'b0;
    w_m0_err    = 1'b0;
    w_m1_err    = 1'b0;
    w_m0_rdata  = '0;
    w_m1_rdata  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (w_done) w_state_nxt = ST_IDLE;
        w_m0_ack = w_done & ~r_owner;
        w_m1_ack = w_done & r_owner;
        w_m0_err = w_timeout & ~r_owner;
        w_m1_err = w_timeout & r_owner;
        if (i_s_ack & ~r_owner) w_m0_rdata = i_s_rdata;
        if (i_s_ack & r_owner)  w_m1_rdata = i_s_rdata;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner   <= 1'b0;
      r_rr_next <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
    end else if (w_grant) begin
      r_owner   <= w_winner;
      r_rr_next <= ~w_winner;
      r_we      <= w_winner ? i_m1_we    : i_m0_we;
      r_addr    <= w_winner ? i_m1_addr  : i_m0_addr;
      r_wdata   <= w_winner ? i_m1_wdata : i_m0_wdata;
      r_be      <= w_winner ? i_m1_be    : i_m0_be;
    end
  end

  assign o_s_req    = (r_state == ST_BUSY);
  assign o_busy     = (r_state == ST_BUSY);
  assign o_owner    = r_owner;
  assign o_s_we     = r_we;
  assign o_s_addr   = r_addr;
  assign o_s_wdata  = r_wdata;
  assign o_s_be     = r_be;
  assign o_m0_ack   = w_m0_ack;
  assign o_m1_ack   = w_m1_ack;
  assign o_m0_err   = w_m0_err;
  assign o_m1_err   = w_m1_err;
  assign o_m0_rdata = w_m0_rdata;
  assign o_m1_rdata = w_m1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_arilla_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_arilla_bus_arbiter -- directed tests of arilla_bus_arbiter against a
// transaction-level model plus a small byte-lane memory. Rev 1.0
// ============================================================================
module tb_arilla_bus_arbiter;

  localparam int c_TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // fixed-priority DUT signals
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic [31:0] rdata_o [2];
  logic [1:0]  ack_o;
  logic [1:0]  err_o;
  logic        s_req, s_we, busy, owner;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic [31:0] s_rdata = '0;
  logic        s_ack   = 1'b0;

  // round-robin DUT signals
  logic        rr_req   = 1'b0;
  logic [31:0] rr_rdata0, rr_rdata1, rr_s_addr, rr_s_wdata;
  logic [1:0]  rr_ack, rr_err;
  logic        rr_s_req, rr_s_we, rr_busy, rr_owner;
  logic [3:0]  rr_s_be;
  logic        rr_s_ack = 1'b0;

  arilla_bus_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(c_TO)) dut_fp (
    .clk(clk), .rst(rst),
    .i_m0_req(req[0]), .i_m0_we(we[0]), .i_m0_addr(addr[0]), .i_m0_wdata(wdata[0]), .i_m0_be(be[0]),
    .o_m0_rdata(rdata_o[0]), .o_m0_ack(ack_o[0]), .o_m0_err(err_o[0]),
    .i_m1_req(req[1]), .i_m1_we(we[1]), .i_m1_addr(addr[1]), .i_m1_wdata(wdata[1]), .i_m1_be(be[1]),
    .o_m1_rdata(rdata_o[1]), .o_m1_ack(ack_o[1]), .o_m1_err(err_o[1]),
    .o_s_req(s_req), .o_s_we(s_we), .o_s_addr(s_addr), .o_s_wdata(s_wdata), .o_s_be(s_be),
    .i_s_rdata(s_rdata), .i_s_ack(s_ack), .o_busy(busy), .o_owner(owner)
  );

  arilla_bus_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(c_TO)) dut_rr (
    .clk(clk), .rst(rst),
    .i_m0_req(rr_req), .i_m0_we(1'b0), .i_m0_addr(32'h0000_0200), .i_m0_wdata(32'h0), .i_m0_be(4'hF),
    .o_m0_rdata(rr_rdata0), .o_m0_ack(rr_ack[0]), .o_m0_err(rr_err[0]),
    .i_m1_req(rr_req), .i_m1_we(1'b0), .i_m1_addr(32'h0000_0300), .i_m1_wdata(32'h0), .i_m1_be(4'hF),
    .o_m1_rdata(rr_rdata1), .o_m1_ack(rr_ack[1]), .o_m1_err(rr_err[1]),
    .o_s_req(rr_s_req), .o_s_we(rr_s_we), .o_s_addr(rr_s_addr), .o_s_wdata(rr_s_wdata), .o_s_be(rr_s_be),
    .i_s_rdata(32'h0), .i_s_ack(rr_s_ack), .o_busy(rr_busy), .o_owner(rr_owner)
  );

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Memory slave: acks lat cycles after the first s_req cycle, byte-lane writes.
  logic [31:0] mem [256];
  int  lat      = 2;
  int  rcnt     = 0;
  bit  slave_en = 1'b1;
  always @(posedge clk) begin
    #1;
    s_ack   = 1'b0;
    s_rdata = '0;
    if (s_req && slave_en) begin
      rcnt++;
      if (rcnt == lat + 1) begin
        rcnt    = 0;
        s_ack   = 1'b1;
        s_rdata = mem[s_addr[9:2]];
        if (s_we)
          for (int b = 0; b < 4; b++)
            if (s_be[b]) mem[s_addr[9:2]][8*b +: 8] = s_wdata[8*b +: 8];
      end
    end else begin
      rcnt = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    rr_s_ack = rr_s_req && !rr_s_ack;
  end

  // Transaction-level model: one access at a time, m1 wins ties.
  bit          m_busy  = 1'b0;
  bit          m_owner = 1'b0;
  bit          m_we    = 1'b0;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_be    = '0;
  int          m_bc    = 0;

  function automatic bit model_timeout();
`ifdef ARILLA_ARB_TIMEOUT_EN
    return m_busy && !s_ack && (m_bc == c_TO);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy  = 1'b0;
      m_owner = 1'b0;
    end else if (!m_busy) begin
      if (req[0] || req[1]) begin
        m_owner = req[1];
        m_busy  = 1'b1;
        m_bc    = 1;
        m_we    = we[m_owner];
        m_addr  = addr[m_owner];
        m_wdata = wdata[m_owner];
        m_be    = be[m_owner];
      end
    end else if (s_ack || model_timeout()) begin
      m_busy = 1'b0;
    end else begin
      m_bc++;
    end
  end

  always @(negedge clk) begin : p_cmp
    bit to;
    bit e_ack;
    if (cmp_en) begin
      to = model_timeout();
      chk("busy",  busy,  m_busy);
      chk("s_req", s_req, m_busy);
      chk("owner", owner, m_owner);
      if (m_busy) begin
        chk("s_we",    s_we,    m_we);
        chk("s_addr",  s_addr,  m_addr);
        chk("s_wdata", s_wdata, m_wdata);
        chk("s_be",    s_be,    m_be);
      end
      for (int k = 0; k < 2; k++) begin
        e_ack = m_busy && (s_ack || to) && (m_owner == k[0]);
        chk($sformatf("m%0d_ack", k), ack_o[k], e_ack);
        chk($sformatf("m%0d_err", k), err_o[k], e_ack && to);
        chk($sformatf("m%0d_rdata", k), rdata_o[k], (e_ack && s_ack) ? s_rdata : 32'h0);
      end
    end
  end

  int  ack_log [$];
  int  rr_log  [$];
  int  sreq_rise [$];
  bit  sreq_prev = 1'b0;
  always @(negedge clk) begin
    if (s_req && !sreq_prev) sreq_rise.push_back(cyc);
    sreq_prev = s_req;
    if (ack_o[0]) ack_log.push_back(0);
    if (ack_o[1]) ack_log.push_back(1);
    if (rr_ack[0]) rr_log.push_back(0);
    if (rr_ack[1]) rr_log.push_back(1);
  end

  task automatic txn(input int m, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] rd, output bit er,
                     output int req_cyc, output int ack_cyc);
    @(posedge clk); #1;
    req[m] = 1'b1; we[m] = w; addr[m] = a; wdata[m] = d; be[m] = b;
    req_cyc = cyc;
    ack_cyc = -1;
    rd = '0;
    er = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack_o[m]) begin
        rd = rdata_o[m]; er = err_o[m]; ack_cyc = cyc;
        break;
      end
    end
    chk($sformatf("m%0d_ack_within_bound", m), (ack_cyc >= 0), 1'b1);
    @(posedge clk); #1;
    req[m] = 1'b0;
  endtask

  logic [31:0] rd0, rd1;
  bit          er0, er1;
  int          rq0, rq1, ak0, ak1, base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0; be[k] = '0;
    end
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[4]  = 32'hCAFE_0010;
    mem[8]  = 32'hA0A0_0020;
    mem[9]  = 32'hB1B1_0024;
    mem[12] = 32'h0000_3030;
    mem[64] = 32'h1234_5678;

    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_s_req", s_req, 1'b0);
    chk("rst_owner", owner, 1'b0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_acks",  ack_o, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;

    // Lone m0 read; its address is disturbed after latching and must be ignored.
    fork
      txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, rd0, er0, rq0, ak0);
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (s_req) break;
        end
        @(posedge clk); #2;
        addr[0] = 32'hFFFF_FFF0;
      end
    join
    chk("t1_rdata", rd0, 32'hCAFE_0010);
    chk("t1_sreq_latency", sreq_rise[$], rq0 + 1);
    chk("t1_ack_latency", ak0, rq0 + 3);
    chk("t1_err", er0, 1'b0);

    // Fixed-priority tie: m1 first, m0 granted two cycles after m1_ack.
    base = ack_log.size();
    fork
      txn(0, 1'b0, 32'h0000_0020, 32'h0, 4'hF, rd0, er0, rq0, ak0);
      txn(1, 1'b0, 32'h0000_0024, 32'h0, 4'hF, rd1, er1, rq1, ak1);
    join
    chk("t2_m1_rdata", rd1, 32'hB1B1_0024);
    chk("t2_m0_rdata", rd0, 32'hA0A0_0020);
    chk("t2_m1_ack_cyc", ak1, rq1 + 3);
    chk("t2_m0_sreq", sreq_rise[$], ak1 + 2);
    chk("t2_m0_ack_cyc", ak0, ak1 + 4);
    chk("t2_order_n", ack_log.size() - base, 2);
    chk("t2_first",  ack_log[base],     1);
    chk("t2_second", ack_log[base + 1], 0);

    // Partial write by m1, then m0 reads the word back.
    txn(1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, rd1, er1, rq1, ak1);
    chk("t3_write_rdata", rd1, 32'h1234_5678);
    txn(0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, rd0, er0, rq0, ak0);
    chk("t3_readback", rd0, 32'h1234_BEEF);

    // Stray s_ack while idle.
    base = ack_log.size();
    @(posedge clk); #2;
    s_ack = 1'b1;
    @(negedge clk);
    chk("t4_idle_ack", ack_o, 2'b00);
    repeat (2) @(posedge clk);
    chk("t4_no_ack_logged", ack_log.size() - base, 0);

    // Reset in the middle of a transaction.
    lat = 20;
    base = ack_log.size();
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0000_0030; be[0] = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_busy_before_rst", busy, 1'b1);
    rst = 1'b1; req[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_s_req_after_rst", s_req, 1'b0);
    chk("t5_busy_after_rst", busy, 1'b0);
    repeat (4) @(posedge clk);
    chk("t5_no_ack", ack_log.size() - base, 0);
    lat = 2;
    txn(0, 1'b0, 32'h0000_0030, 32'h0, 4'hF, rd0, er0, rq0, ak0);
    chk("t5_after_rst_rdata", rd0, 32'h0000_3030);
    chk("t5_after_rst_lat", ak0, rq0 + 3);

    // Round-robin instance: both masters request continuously.
    @(posedge clk); #1;
    rr_req = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rr_log.size() >= 4) break;
    end
    @(posedge clk); #1;
    rr_req = 1'b0;
    chk("t6_rr_count_ge4", (rr_log.size() >= 4), 1'b1);
    chk("t6_rr_0", rr_log[0], 0);
    chk("t6_rr_1", rr_log[1], 1);
    chk("t6_rr_2", rr_log[2], 0);
    chk("t6_rr_3", rr_log[3], 1);

`ifdef ARILLA_ARB_TIMEOUT_EN
    // Silent slave: watchdog completes on the 8th BUSY cycle.
    slave_en = 1'b0;
    txn(0, 1'b0, 32'h0000_0040, 32'h0, 4'hF, rd0, er0, rq0, ak0);
    chk("t7_err", er0, 1'b1);
    chk("t7_rdata", rd0, 32'h0);
    chk("t7_ack_cyc", ak0, rq0 + 1 + (c_TO - 1));
    base = ack_log.size();
    @(posedge clk); #2;
    s_ack = 1'b1;
    @(negedge clk);
    chk("t7_late_ack", ack_o, 2'b00);
    repeat (2) @(posedge clk);
    chk("t7_no_ack_logged", ack_log.size() - base, 0);
    slave_en = 1'b1;
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
